// File: rtl/intc_prio.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : intc_prio
// Brief    : Parametrised fixed-priority interrupt controller with a
//            memory-mapped register port and an IRQ/IACK handshake.
// Revision : 1.0
// ============================================================================

module intc_prio #(
  parameter  int NUM_SRC = 8,
  localparam int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] done,
  input  logic               IACK,
  input  logic [31:0]        input_addr,
  input  logic               write_enable,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               IRQ,
  output logic [31:0]        isr_addr,
  output logic [ID_W-1:0]    irq_id
);

  localparam logic [7:0] A_ENABLE  = 8'h40;
  localparam logic [7:0] A_PENDING = 8'h41;
  localparam logic [7:0] A_MODE    = 8'h42;
  localparam logic [7:0] A_STATUS  = 8'h43;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ASSERT = 2'b01,
    S_ACK    = 2'b10
  } state_t;

  state_t             state, state_d;
  logic [31:0]        vec [NUM_SRC];
  logic [NUM_SRC-1:0] enable, mode, done_q, pend_edge;
  logic [NUM_SRC-1:0] pending, req, set_ev, clr_w1c, clr_ack;
  logic [7:0]         addr;
  logic               vec_sel;
  logic [ID_W-1:0]    win, id_d;
  logic [31:0]        isr_d;
  logic               irq_d, ack_take;
  logic               unused_addr_bits;

  assign addr             = input_addr[7:0];
  assign unused_addr_bits = ^input_addr[31:8];
  assign vec_sel          = 32'(addr) < NUM_SRC;

  // Level sources mirror the registered line; edge sources use the sticky latch.
  assign set_ev  = done & ~done_q;
  assign clr_w1c = (write_enable && addr == A_PENDING) ? write_data[NUM_SRC-1:0] : '0;
  assign clr_ack = ack_take ? (NUM_SRC'(1) << irq_id) : '0;
  assign pending = (mode & done_q) | (~mode & pend_edge);
  assign req     = pending & enable;

  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) win = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state;
    irq_d    = IRQ;
    id_d     = irq_id;
    isr_d    = isr_addr;
    ack_take = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) begin
          state_d = S_ASSERT;
          irq_d   = 1'b1;
          id_d    = win;
          isr_d   = vec[win];
        end
      end
      S_ASSERT: begin
        if (IACK) begin
          state_d  = S_ACK;
          irq_d    = 1'b0;
          ack_take = 1'b1;
        end
      end
      S_ACK: begin
        if (!IACK) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      IRQ      <= 1'b0;
      irq_id   <= '0;
      isr_addr <= '0;
    end else begin
      state    <= state_d;
      IRQ      <= irq_d;
      irq_id   <= id_d;
      isr_addr <= isr_d;
    end
  end

  // Set beats any same-cycle clear (W1C or acknowledge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= '0;
      pend_edge <= '0;
    end else begin
      done_q    <= done;
      pend_edge <= ~mode & ((pend_edge & ~(clr_w1c | clr_ack)) | set_ev);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) vec[i] <= '0;
      enable <= '0;
      mode   <= '0;
    end else if (write_enable) begin
      if (vec_sel) vec[addr[ID_W-1:0]] <= write_data;
      case (addr)
        A_ENABLE: enable <= write_data[NUM_SRC-1:0];
        A_MODE:   mode   <= write_data[NUM_SRC-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    read_data = '0;
    if (vec_sel) begin
      read_data = vec[addr[ID_W-1:0]];
    end else begin
      case (addr)
        A_ENABLE:  read_data = 32'(enable);
        A_PENDING: read_data = 32'(pending);
        A_MODE:    read_data = 32'(mode);
        A_STATUS: begin
          read_data[9:8]      = state;
          read_data[ID_W-1:0] = irq_id;
        end
        default:   read_data = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_intc_prio.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_intc_prio
// Brief    : Directed self-checking bench for intc_prio (8- and 32-source).
// Revision : 1.0
// ============================================================================

module tb_intc_prio;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  done;
  logic        iack, write_enable, irq;
  logic [31:0] input_addr, write_data, read_data, isr_addr;
  logic [2:0]  irq_id;

  logic [31:0] done32;
  logic        iack32, we32, irq32;
  logic [31:0] addr32, wdata32, rdata32, isr32;
  logic [4:0]  id32;

  intc_prio #(.NUM_SRC(8)) dut (
    .clk(clk), .rst(rst), .done(done), .IACK(iack),
    .input_addr(input_addr), .write_enable(write_enable),
    .write_data(write_data), .read_data(read_data),
    .IRQ(irq), .isr_addr(isr_addr), .irq_id(irq_id)
  );

  intc_prio #(.NUM_SRC(32)) dut32 (
    .clk(clk), .rst(rst), .done(done32), .IACK(iack32),
    .input_addr(addr32), .write_enable(we32),
    .write_data(wdata32), .read_data(rdata32),
    .IRQ(irq32), .isr_addr(isr32), .irq_id(id32)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    input_addr   = {24'h0, a};
    write_data   = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    push(tag, exp);
    input_addr = {24'h0, a};
    #0.1;
    check(read_data);
  endtask

  task automatic rdchk32(input string tag, input logic [7:0] a, input logic [31:0] exp);
    push(tag, exp);
    addr32 = {24'h0, a};
    #0.1;
    check(rdata32);
  endtask

  // Outputs expected after the next edge: irq, irq_id, isr_addr.
  task automatic expect_out(input string tag, input logic i, input logic [2:0] id,
                            input logic [31:0] isr);
    push({tag, "_irq"}, 32'(i));
    push({tag, "_id"}, 32'(id));
    push({tag, "_isr"}, isr);
  endtask

  task automatic check_out();
    check(32'(irq));
    check(32'(irq_id));
    check(isr_addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    done = '0; iack = 1'b0; write_enable = 1'b0; input_addr = '0; write_data = '0;
    done32 = '0; iack32 = 1'b0; we32 = 1'b0; addr32 = '0; wdata32 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Post-reset register map
    rdchk("rst_enable", 8'h40, 32'h0);
    rdchk("rst_pending", 8'h41, 32'h0);
    rdchk("rst_mode", 8'h42, 32'h0);
    rdchk("rst_status", 8'h43, 32'h0);
    rdchk("rst_vec3", 8'h03, 32'h0);
    push("rst_irq", 32'h0); check(32'(irq));

    // Single edge source
    wr(8'h03, 32'h0000_0300);
    wr(8'h40, 32'h08);
    done[3] = 1'b1;
    push("t2_irq_k", 32'h0);
    tick();
    done[3] = 1'b0;
    check(32'(irq));
    rdchk("t2_pend_k", 8'h41, 32'h08);
    expect_out("t2_k1", 1'b1, 3'd3, 32'h300);
    tick();
    check_out();
    rdchk("t2_status_assert", 8'h43, 32'h103);
    iack = 1'b1;
    push("t2_irq_ack", 32'h0);
    tick();
    check(32'(irq));
    rdchk("t2_pend_ack", 8'h41, 32'h0);
    rdchk("t2_status_ack", 8'h43, 32'h203);
    iack = 1'b0;
    tick();
    rdchk("t2_status_idle", 8'h43, 32'h003);

    // Priority without preemption
    wr(8'h05, 32'h0000_0500);
    wr(8'h01, 32'h0000_0100);
    wr(8'h40, 32'h22);
    done[5] = 1'b1;
    tick();
    done[5] = 1'b0;
    expect_out("t3_a5", 1'b1, 3'd5, 32'h500);
    tick();
    check_out();
    done[1] = 1'b1;
    tick();
    done[1] = 1'b0;
    expect_out("t3_hold5", 1'b1, 3'd5, 32'h500);
    tick();
    check_out();
    rdchk("t3_pend_both", 8'h41, 32'h22);
    iack = 1'b1;
    push("t3_irq_ack", 32'h0);
    tick();
    check(32'(irq));
    rdchk("t3_pend_after_ack", 8'h41, 32'h02);
    iack = 1'b0;
    push("t3_irq_to_idle", 32'h0);
    tick();
    check(32'(irq));
    expect_out("t3_a1", 1'b1, 3'd1, 32'h100);
    tick();
    check_out();
    iack = 1'b1; tick();
    iack = 1'b0; tick();
    rdchk("t3_pend_clear", 8'h41, 32'h0);

    // Masking and W1C
    wr(8'h40, 32'h0);
    done[2] = 1'b1;
    tick();
    done[2] = 1'b0;
    tick();
    rdchk("t4_pend_masked", 8'h41, 32'h04);
    push("t4_irq_masked", 32'h0); check(32'(irq));
    input_addr = 32'h41; write_data = 32'h04; write_enable = 1'b1; done[2] = 1'b1;
    tick();
    write_enable = 1'b0; done[2] = 1'b0;
    rdchk("t4_set_wins", 8'h41, 32'h04);
    wr(8'h40, 32'h04);
    push("t4_irq_after_en_write", 32'h0); check(32'(irq));
    push("t4_irq_en", 32'h1);
    push("t4_id_en", 32'h2);
    tick();
    check(32'(irq));
    check(32'(irq_id));
    iack = 1'b1;
    tick();
    rdchk("t4_pend_acked", 8'h41, 32'h0);
    iack = 1'b0;
    tick();
    wr(8'h40, 32'h0);
    done[2] = 1'b1;
    tick(); tick();
    rdchk("t4_held_once", 8'h41, 32'h04);
    wr(8'h41, 32'h04);
    rdchk("t4_w1c", 8'h41, 32'h0);
    tick();
    rdchk("t4_held_no_rearm", 8'h41, 32'h0);
    done[2] = 1'b0;
    tick();
    iack = 1'b1;
    tick();
    iack = 1'b0;
    rdchk("t4_iack_idle_ignored", 8'h43, 32'h002);

    // Level mode
    wr(8'h00, 32'h0000_00A0);
    wr(8'h42, 32'h01);
    wr(8'h40, 32'h01);
    done[0] = 1'b1;
    tick();
    push("t5_irq_k", 32'h0); check(32'(irq));
    rdchk("t5_pend_level", 8'h41, 32'h01);
    expect_out("t5_a0", 1'b1, 3'd0, 32'hA0);
    tick();
    check_out();
    wr(8'h41, 32'h01);
    rdchk("t5_w1c_no_effect", 8'h41, 32'h01);
    iack = 1'b1;
    push("t5_irq_ack", 32'h0);
    tick();
    check(32'(irq));
    rdchk("t5_pend_kept", 8'h41, 32'h01);
    iack = 1'b0;
    push("t5_irq_to_idle", 32'h0);
    tick();
    check(32'(irq));
    expect_out("t5_refire", 1'b1, 3'd0, 32'hA0);
    tick();
    check_out();
    iack = 1'b1;
    tick();
    iack = 1'b0; done[0] = 1'b0;
    tick(); tick(); tick();
    push("t5_no_more_irq", 32'h0); check(32'(irq));
    rdchk("t5_pend_dropped", 8'h41, 32'h0);

    // Out-of-range vector slot on the 8-source build
    wr(8'h08, 32'h0000_1234);
    rdchk("t6_vec8_unmapped", 8'h08, 32'h0);

    // Asynchronous reset mid-handshake
    wr(8'h40, 32'h08);
    done[3] = 1'b1;
    tick();
    done[3] = 1'b0;
    expect_out("t6_pre_rst", 1'b1, 3'd3, 32'h300);
    tick();
    check_out();
    #2;
    rst = 1'b1;
    #0.5;
    push("t6_rst_irq", 32'h0); check(32'(irq));
    push("t6_rst_isr", 32'h0); check(isr_addr);
    push("t6_rst_id", 32'h0); check(32'(irq_id));
    rdchk("t6_rst_status", 8'h43, 32'h0);
    rdchk("t6_rst_enable", 8'h40, 32'h0);
    rdchk("t6_rst_mode", 8'h42, 32'h0);
    rdchk("t6_rst_vec3", 8'h03, 32'h0);
    rdchk("t6_rst_vec5", 8'h05, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    push("t6_post_rst_irq", 32'h0); check(32'(irq));

    // 32-source build: highest source and out-of-range slot
    addr32 = 32'd31; wdata32 = 32'hDEAD_0031; we32 = 1'b1;
    tick();
    addr32 = 32'h40; wdata32 = 32'h8000_0000;
    tick();
    addr32 = 32'h20; wdata32 = 32'h0000_FFFF;
    tick();
    we32 = 1'b0;
    done32[31] = 1'b1;
    tick();
    done32[31] = 1'b0;
    push("t7_irq32", 32'h1);
    push("t7_id32", 32'd31);
    push("t7_isr32", 32'hDEAD_0031);
    tick();
    check(32'(irq32));
    check(32'(id32));
    check(isr32);
    rdchk32("t7_vec32_unmapped", 8'h20, 32'h0);
    rdchk32("t7_vec31", 8'h1F, 32'hDEAD_0031);
    rdchk32("t7_status32", 8'h43, 32'h11F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
